if_id_stage: RTL and testbench

IF/ID pipeline register and decode front end of the 16-bit processor. Latches each fetched instruction and its PC, then decodes the register fields that drive the register bank's read ports, along with destination, immediate and control bits. Detects load-use hazards against the instruction in EX and stalls fetch for one cycle. Handles branch flush.

---
 rtl/cpu16_pkg.sv | 57 +++++
 rtl/hazard_detect.sv | 22 ++
 rtl/if_id_stage.sv | 121 ++++++++++++
 tb/tb_if_id_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit processor: opcodes, instruction field
// positions and the decoded control bundle carried into ID/EX.
package cpu16_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int OPC_W  = 4;
    localparam int IMM_W  = 6;

    localparam int OPC_LSB = 12;
    localparam int RS_LSB  = 9;
    localparam int RT_LSB  = 6;
    localparam int RD_LSB  = 3;
    localparam int IMM_LSB = 0;

    localparam logic [OPC_W-1:0] OP_R    = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADDI = 4'h1;
    localparam logic [OPC_W-1:0] OP_LW   = 4'h2;
    localparam logic [OPC_W-1:0] OP_SW   = 4'h3;
    localparam logic [OPC_W-1:0] OP_BEQ  = 4'h4;
    localparam logic [OPC_W-1:0] OP_J    = 4'h5;
    localparam logic [OPC_W-1:0] OP_NOP  = 4'hF;

    localparam logic [DATA_W-1:0] NOP_WORD = 16'hF000;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic alu_src;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // Unknown opcodes fall through to the NOP bundle.
    function automatic ctrl_t decode_ctrl(input logic [OPC_W-1:0] op);
        ctrl_t c;
        c = CTRL_NONE;
        case (op)
            OP_R:    c.reg_write = 1'b1;
            OP_ADDI: begin c.reg_write = 1'b1; c.alu_src = 1'b1; end
            OP_LW:   begin c.reg_write = 1'b1; c.mem_read = 1'b1; c.alu_src = 1'b1; end
            OP_SW:   begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
            OP_BEQ:  c.branch = 1'b1;
            OP_J:    c.branch = 1'b1;
            OP_NOP:  c = CTRL_NONE;
            default: c = CTRL_NONE;
        endcase
        return c;
    endfunction

    function automatic logic reads_rt(input logic [OPC_W-1:0] op);
        return (op == OP_R) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags when the live ID instruction reads the register
// that a load in EX has not yet produced. Register 0 never hazards.
module hazard_detect
    import cpu16_pkg::*;
(
    input  logic             i_valid,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_dest,
    input  logic [REG_W-1:0] i_rs,
    input  logic [REG_W-1:0] i_rt,
    input  logic             i_uses_rt,
    output logic             o_stall
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = (i_ex_dest == i_rs);
    assign w_rt_hit = i_uses_rt && (i_ex_dest == i_rt);
    assign o_stall  = i_valid && i_ex_mem_read && (i_ex_dest != '0) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with combinational decode, load-use stall and
// branch flush. Decoded controls are bubbled whenever the stage is dead or stalled.
module if_id_stage
    import cpu16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             fetch_valid,
    input  logic [WIDTH-1:0] instr_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             flush,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_dest,
    output logic             stall,
    output logic             valid_out,
    output logic [WIDTH-1:0] pc_out,
    output logic [OPC_W-1:0] opcode,
    output logic [REG_W-1:0] rs,
    output logic [REG_W-1:0] rt,
    output logic [REG_W-1:0] dest,
    output logic [WIDTH-1:0] imm,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch,
    output logic             alu_src,
    output logic [15:0]      stall_count
);

    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_pc;
    logic             r_valid;
    logic [15:0]      r_stall_count;

    logic [OPC_W-1:0] w_op;
    logic [REG_W-1:0] w_rs;
    logic [REG_W-1:0] w_rt;
    logic [REG_W-1:0] w_rd;
    ctrl_t            w_ctrl;
    logic             w_uses_rt;
    logic             w_stall;

    assign w_op      = r_instr[OPC_LSB +: OPC_W];
    assign w_rs      = r_instr[RS_LSB +: REG_W];
    assign w_rt      = r_instr[RT_LSB +: REG_W];
    assign w_rd      = r_instr[RD_LSB +: REG_W];
    assign w_ctrl    = decode_ctrl(w_op);
    assign w_uses_rt = reads_rt(w_op);

    hazard_detect u_hazard (
        .i_valid       (r_valid),
        .i_ex_mem_read (ex_mem_read),
        .i_ex_dest     (ex_dest),
        .i_rs          (w_rs),
        .i_rt          (w_rt),
        .i_uses_rt     (w_uses_rt),
        .o_stall       (w_stall)
    );

    // Fetch handshake: fetch_valid qualifies instr_in/pc_in in a cycle; the word
    // is consumed at the next edge only when stall and flush are both low, so
    // fetch must hold PC and present the same word again while stall is high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_instr       <= NOP_WORD;
            r_pc          <= '0;
            r_valid       <= 1'b0;
            r_stall_count <= '0;
        end else begin
            if (flush) begin
                r_instr <= NOP_WORD;
                r_valid <= 1'b0;
            end else if (!w_stall) begin
                if (fetch_valid) begin
                    r_instr <= instr_in;
                    r_pc    <= pc_in;
                    r_valid <= 1'b1;
                end else begin
                    r_instr <= NOP_WORD;
                    r_valid <= 1'b0;
                end
            end
            if (w_stall && !flush && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    always_comb begin
        dest      = '0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        alu_src   = 1'b0;
        case (w_op)
            OP_R:          dest = w_rd;
            OP_ADDI, OP_LW: dest = w_rt;
            default:       dest = '0;
        endcase
        if (r_valid && !w_stall) begin
            reg_write = w_ctrl.reg_write;
            mem_read  = w_ctrl.mem_read;
            mem_write = w_ctrl.mem_write;
            branch    = w_ctrl.branch;
            alu_src   = w_ctrl.alu_src;
        end
    end

    assign stall       = w_stall;
    assign valid_out   = r_valid;
    assign pc_out      = r_pc;
    assign opcode      = w_op;
    assign rs          = w_rs;
    assign rt          = w_rt;
    assign imm         = {{(WIDTH-IMM_W){r_instr[IMM_LSB+IMM_W-1]}}, r_instr[IMM_LSB +: IMM_W]};
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized scoreboard bench for if_id_stage: the driver pushes the expected
// per-cycle outputs from a behavioural model; the monitor pops and compares.
module tb_if_id_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fetch_valid;
    logic [15:0] instr_in;
    logic [15:0] pc_in;
    logic        flush;
    logic        ex_mem_read;
    logic [2:0]  ex_dest;
    logic        stall;
    logic        valid_out;
    logic [15:0] pc_out;
    logic [3:0]  opcode;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  dest;
    logic [15:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        alu_src;
    logic [15:0] stall_count;

    always #5 clock = ~clock;

    if_id_stage #(.WIDTH(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .fetch_valid (fetch_valid),
        .instr_in    (instr_in),
        .pc_in       (pc_in),
        .flush       (flush),
        .ex_mem_read (ex_mem_read),
        .ex_dest     (ex_dest),
        .stall       (stall),
        .valid_out   (valid_out),
        .pc_out      (pc_out),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .dest        (dest),
        .imm         (imm),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .branch      (branch),
        .alu_src     (alu_src),
        .stall_count (stall_count)
    );

    typedef struct packed {
        logic        stall;
        logic        valid;
        logic [15:0] pc;
        logic [3:0]  opc;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  dest;
        logic [15:0] imm;
        logic [4:0]  ctrl;
        logic [15:0] cnt;
    } exp_t;

    localparam int EXP_W = $bits(exp_t);

    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model of the stage contents.
    logic [15:0] m_instr;
    logic [15:0] m_pc;
    bit          m_valid;
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    function automatic exp_t model_outputs(input bit exmr, input logic [2:0] exd);
        exp_t e;
        int   op;
        int   f_rs;
        int   f_rt;
        int   f_rd;
        bit   uses_rt;
        bit   live;
        bit   rw, mr, mw, br, as;
        op   = m_instr / 4096;
        f_rs = (m_instr / 512) % 8;
        f_rt = (m_instr / 64) % 8;
        f_rd = (m_instr / 8) % 8;
        uses_rt = (op == 0) || (op == 3) || (op == 4);
        e.stall = m_valid && exmr && (exd != 0) && ((exd == f_rs) || (uses_rt && (exd == f_rt)));
        e.valid = m_valid;
        e.pc    = m_pc;
        e.opc   = 4'(op);
        e.rs    = 3'(f_rs);
        e.rt    = 3'(f_rt);
        if (op == 0)                 e.dest = 3'(f_rd);
        else if (op == 1 || op == 2) e.dest = 3'(f_rt);
        else                         e.dest = 3'd0;
        if ((m_instr % 64) >= 32) e.imm = 16'((m_instr % 64) + 65536 - 64);
        else                      e.imm = 16'(m_instr % 64);
        live = m_valid && !e.stall;
        rw = live && (op == 0 || op == 1 || op == 2);
        mr = live && (op == 2);
        mw = live && (op == 3);
        br = live && (op == 4 || op == 5);
        as = live && (op == 1 || op == 2 || op == 3);
        e.ctrl = {rw, mr, mw, br, as};
        e.cnt  = 16'(m_cnt);
        return e;
    endfunction

    task automatic drive(input bit rst_v, input bit fv, input logic [15:0] ins, input logic [15:0] pc,
                         input bit fl, input bit exmr, input logic [2:0] exd);
        exp_t e;
        @(negedge clock);
        reset_n     = rst_v;
        fetch_valid = fv;
        instr_in    = ins;
        pc_in       = pc;
        flush       = fl;
        ex_mem_read = exmr;
        ex_dest     = exd;
        if (!rst_v) begin
            m_instr = 16'hF000;
            m_pc    = 16'h0000;
            m_valid = 0;
            m_cnt   = 0;
        end
        e = model_outputs(exmr, exd);
        exp_q.push_back(e);
        if (rst_v) begin
            if (e.stall && !fl && m_cnt < 65535) m_cnt++;
            if (fl) begin
                m_instr = 16'hF000;
                m_valid = 0;
            end else if (!e.stall) begin
                if (fv) begin
                    m_instr = ins;
                    m_pc    = pc;
                    m_valid = 1;
                end else begin
                    m_instr = 16'hF000;
                    m_valid = 0;
                end
            end
        end
    endtask

    // Monitor: samples mid-low-phase, away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_t'(exp_q.pop_front());
                check("stall",       32'(stall),       32'(e.stall));
                check("valid_out",   32'(valid_out),   32'(e.valid));
                check("pc_out",      32'(pc_out),      32'(e.pc));
                check("opcode",      32'(opcode),      32'(e.opc));
                check("rs",          32'(rs),          32'(e.rs));
                check("rt",          32'(rt),          32'(e.rt));
                check("dest",        32'(dest),        32'(e.dest));
                check("imm",         32'(imm),         32'(e.imm));
                check("controls",    32'({reg_write, mem_read, mem_write, branch, alu_src}), 32'(e.ctrl));
                check("stall_count", 32'(stall_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        n_errors++;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  ops[7];
        logic [15:0] r_ins;
        reset_n = 1'b0; fetch_valid = 1'b0; instr_in = '0; pc_in = '0;
        flush = 1'b0; ex_mem_read = 1'b0; ex_dest = '0;
        m_instr = 16'hF000; m_pc = '0; m_valid = 0; m_cnt = 0;
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hF};

        // Reset held with a live fetch presented.
        repeat (3) drive(0, 1, 16'h1234, 16'h0040, 0, 0, 3'd0);

        // ADDI decode, negative immediate, no false hazard on ADDI rt.
        drive(1, 1, 16'h1283, 16'h0010, 0, 0, 3'd0);
        drive(1, 1, 16'h12BF, 16'h0012, 0, 0, 3'd0);
        drive(1, 1, 16'h0298, 16'h0014, 0, 1, 3'd2);
        // Load-use on rt: one stall cycle, then release.
        drive(1, 1, 16'h3000, 16'h0016, 0, 1, 3'd2);
        drive(1, 1, 16'h3000, 16'h0016, 0, 0, 3'd0);
        drive(1, 1, 16'h0298, 16'h0018, 0, 1, 3'd0);
        // Flush during a stall wins.
        drive(1, 0, 16'h0000, 16'h0000, 0, 1, 3'd1);
        drive(1, 1, 16'h1283, 16'h001A, 1, 1, 3'd1);
        drive(1, 0, 16'h0000, 16'h0000, 0, 0, 3'd0);
        // Reset asserted mid-stall, then clean release.
        drive(1, 1, 16'h0298, 16'h0020, 0, 0, 3'd0);
        drive(1, 1, 16'h1283, 16'h0022, 0, 1, 3'd1);
        drive(0, 1, 16'h1283, 16'h0022, 0, 1, 3'd1);
        drive(1, 0, 16'h0000, 16'h0000, 0, 1, 3'd1);
        drive(1, 0, 16'h0000, 16'h0000, 0, 0, 3'd0);

        // Saturation of the stall counter.
        drive(1, 1, 16'h0298, 16'h0030, 0, 0, 3'd0);
        repeat (65540) drive(1, 0, 16'h0000, 16'h0000, 0, 1, 3'd1);
        drive(1, 0, 16'h0000, 16'h0000, 0, 0, 3'd0);
        drive(0, 0, 16'h0000, 16'h0000, 0, 0, 3'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r_ins = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) != 0) r_ins[15:12] = ops[$urandom_range(0, 6)];
            drive($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, r_ins,
                  16'($urandom_range(0, 65535)), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
        end
        drive(1, 0, 16'h0000, 16'h0000, 0, 0, 3'd0);

        @(negedge clock);
        #5;
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
